// File: rtl/j11pkg.sv
// Shared definitions for the J11 DMA arbiter: FSM encodings and counter sizing.
package j11pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/j11rrpick.sv
// Combinational round-robin picker: first set candidate strictly after ptr, wrapping.
module j11rrpick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  cand,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    always_comb begin
        int j;
        logic [IW-1:0] jx;
        j     = 0;
        jx    = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            j  = (int'(ptr) + k) % N;
            jx = IW'(j);
            if (!valid && cand[jx]) begin
                valid = 1'b1;
                idx   = jx;
            end
        end
    end

endmodule

// File: rtl/j11dmaarb.sv
// Round-robin arbiter sharing the single Unibus DMA port of the memory mux among N masters.
module j11dmaarb
    import j11pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [N-1:0]    mreq,
    input  logic [N-1:0]    mwr,
    input  logic [18*N-1:0] maddr,
    input  logic [16*N-1:0] mwdata,
    output logic [N-1:0]    mack,
    output logic [15:0]     mrdata,
    output logic            merr,
    output logic            dmareq,
    output logic            dmawr,
    output logic [17:0]     dmaaddr,
    output logic [15:0]     dmawdata,
    input  logic            dmaack,
    input  logic [15:0]     dmardata,
    input  logic            dmaerr,
    output logic            busy
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = cnt_width(TIMEOUT);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] gnt_q, gnt_d;
    logic [N-1:0]  pend_q, pend_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dmareq_q, dmareq_d;
    logic          dmawr_q, dmawr_d;
    logic [17:0]   dmaaddr_q, dmaaddr_d;
    logic [15:0]   dmawdata_q, dmawdata_d;
    logic [N-1:0]  mack_q, mack_d;
    logic [15:0]   mrdata_q, mrdata_d;
    logic          merr_q, merr_d;
    logic          busy_q, busy_d;

    logic [17:0]   maddr_a  [N];
    logic [15:0]   mwdata_a [N];
    logic [N-1:0]  cand;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;

    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign maddr_a[gi]  = maddr[18*gi +: 18];
        assign mwdata_a[gi] = mwdata[16*gi +: 16];
    end

    // A pulse arriving in the IDLE cycle competes directly, giving 1-cycle latency.
    assign cand = mreq | pend_q;

    j11rrpick #(.N(N), .IW(IW)) u_pick (
        .cand  (cand),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        pend_d     = pend_q | mreq;
        cnt_d      = cnt_q;
        dmareq_d   = 1'b0;
        dmawr_d    = dmawr_q;
        dmaaddr_d  = dmaaddr_q;
        dmawdata_d = dmawdata_q;
        mack_d     = '0;
        mrdata_d   = mrdata_q;
        merr_d     = merr_q;
        busy_d     = busy_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    gnt_d            = pick_idx;
                    ptr_d            = pick_idx;
                    pend_d[pick_idx] = 1'b0;
                    dmareq_d         = 1'b1;
                    dmawr_d          = mwr[pick_idx];
                    dmaaddr_d        = maddr_a[pick_idx];
                    dmawdata_d       = mwdata_a[pick_idx];
                    busy_d           = 1'b1;
                    state_d          = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                cnt_d   = CW'(1);
                state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                // A real ack wins over a timeout landing in the same cycle.
                if (dmaack || cnt_q == CW'(TIMEOUT - 1)) begin
                    mack_d[gnt_q] = 1'b1;
                    mrdata_d      = dmaack ? dmardata : 16'd0;
                    merr_d        = dmaack ? dmaerr : 1'b1;
                    busy_d        = 1'b0;
                    cnt_d         = '0;
                    state_d       = ARB_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ARB_IDLE;
            ptr_q      <= IW'(N - 1);
            gnt_q      <= '0;
            pend_q     <= '0;
            cnt_q      <= '0;
            dmareq_q   <= 1'b0;
            dmawr_q    <= 1'b0;
            dmaaddr_q  <= '0;
            dmawdata_q <= '0;
            mack_q     <= '0;
            mrdata_q   <= '0;
            merr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            dmareq_q   <= dmareq_d;
            dmawr_q    <= dmawr_d;
            dmaaddr_q  <= dmaaddr_d;
            dmawdata_q <= dmawdata_d;
            mack_q     <= mack_d;
            mrdata_q   <= mrdata_d;
            merr_q     <= merr_d;
            busy_q     <= busy_d;
        end
    end

    assign dmareq   = dmareq_q;
    assign dmawr    = dmawr_q;
    assign dmaaddr  = dmaaddr_q;
    assign dmawdata = dmawdata_q;
    assign mack     = mack_q;
    assign mrdata   = mrdata_q;
    assign merr     = merr_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_j11dmaarb.sv
// Directed bench for j11dmaarb with a transaction-level reference model checked every cycle.
module tb_j11dmaarb;

    localparam int N  = 4;
    localparam int TO = 8;

    logic            clk      = 1'b0;
    logic            rstn     = 1'b0;
    logic [N-1:0]    mreq     = '0;
    logic [N-1:0]    mwr      = '0;
    logic [18*N-1:0] maddr    = '0;
    logic [16*N-1:0] mwdata   = '0;
    logic            dmaack   = 1'b0;
    logic [15:0]     dmardata = '0;
    logic            dmaerr   = 1'b0;
    logic [N-1:0]    mack;
    logic [15:0]     mrdata;
    logic            merr;
    logic            dmareq;
    logic            dmawr;
    logic [17:0]     dmaaddr;
    logic [15:0]     dmawdata;
    logic            busy;

    int n_cmp = 0;
    int n_bad = 0;
    int pc    = 0;

    j11dmaarb #(.N(N), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .mreq     (mreq),
        .mwr      (mwr),
        .maddr    (maddr),
        .mwdata   (mwdata),
        .mack     (mack),
        .mrdata   (mrdata),
        .merr     (merr),
        .dmareq   (dmareq),
        .dmawr    (dmawr),
        .dmaaddr  (dmaaddr),
        .dmawdata (dmawdata),
        .dmaack   (dmaack),
        .dmardata (dmardata),
        .dmaerr   (dmaerr),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pc <= pc + 1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, pc, got, exp);
        end
    endtask

    // Reference model: pending set, rotating pointer, and the cycle the current dmareq appeared.
    logic [N-1:0] m_pend  = '0;
    logic [N-1:0] m_cand  = '0;
    int           m_ptr   = N - 1;
    bit           m_act   = 1'b0;
    bit           m_found = 1'b0;
    int           m_gnt   = 0;
    int           m_issue = 0;
    logic         e_dmareq = 1'b0, e_dmawr = 1'b0, e_merr = 1'b0, e_busy = 1'b0;
    logic [17:0]  e_addr  = '0;
    logic [15:0]  e_wdata = '0, e_rdata = '0;
    logic [N-1:0] e_mack  = '0;

    initial forever begin
        @(posedge clk or negedge rstn);
        if (!rstn) begin
            m_pend = '0; m_ptr = N - 1; m_act = 1'b0;
            e_dmareq = 1'b0; e_dmawr = 1'b0; e_merr = 1'b0; e_busy = 1'b0;
            e_addr = '0; e_wdata = '0; e_rdata = '0; e_mack = '0;
        end else begin
            e_dmareq = 1'b0;
            e_mack   = '0;
            if (m_act) begin
                if (pc > m_issue && dmaack === 1'b1) begin
                    e_mack[m_gnt] = 1'b1; e_rdata = dmardata; e_merr = dmaerr; m_act = 1'b0;
                end else if (pc + 1 - m_issue == TO) begin
                    e_mack[m_gnt] = 1'b1; e_rdata = 16'd0; e_merr = 1'b1; m_act = 1'b0;
                end
                m_pend = m_pend | mreq;
            end else begin
                m_cand = m_pend | mreq;
                if (m_cand != '0) begin
                    m_found = 1'b0;
                    for (int k = 1; k <= N; k++) begin
                        if (!m_found && m_cand[(m_ptr + k) % N]) begin
                            m_gnt = (m_ptr + k) % N; m_found = 1'b1;
                        end
                    end
                    m_ptr = m_gnt; m_act = 1'b1; m_issue = pc + 1;
                    e_dmareq = 1'b1; e_dmawr = mwr[m_gnt];
                    e_addr = maddr[18*m_gnt +: 18]; e_wdata = mwdata[16*m_gnt +: 16];
                    m_pend = m_cand; m_pend[m_gnt] = 1'b0;
                end
            end
            e_busy = m_act;
        end
    end

    int req_cnt = 0, req_cyc = 0, mack_cnt = 0, mack_cyc = 0, pulse_cyc = 0;
    logic [17:0]  req_addr = '0;
    logic [15:0]  req_wd = '0, mack_rd = '0;
    logic         req_wr = 1'b0, mack_er = 1'b0;
    logic [N-1:0] mack_v = '0;
    int order[$];
    int exp_rr[5] = '{0, 2, 3, 0, 3};

    function automatic int master_of(input logic [17:0] a);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (maddr[18*i +: 18] == a) r = i;
        return r;
    endfunction

    // Per-cycle comparison against the model plus an event log for the directed checks.
    initial forever begin
        @(negedge clk);
        check("dmareq",   32'(dmareq),   32'(e_dmareq));
        check("dmawr",    32'(dmawr),    32'(e_dmawr));
        check("dmaaddr",  32'(dmaaddr),  32'(e_addr));
        check("dmawdata", 32'(dmawdata), 32'(e_wdata));
        check("mack",     32'(mack),     32'(e_mack));
        check("mrdata",   32'(mrdata),   32'(e_rdata));
        check("merr",     32'(merr),     32'(e_merr));
        check("busy",     32'(busy),     32'(e_busy));
        if (dmareq === 1'b1) begin
            req_cnt++; req_cyc = pc; req_addr = dmaaddr; req_wr = dmawr; req_wd = dmawdata;
            order.push_back(master_of(dmaaddr));
            $display("cyc=%0d dmareq master=%0d wr=%0d addr=%o wdata=%o", pc, master_of(dmaaddr), dmawr, dmaaddr, dmawdata);
        end
        if (mack !== '0) begin
            mack_cnt++; mack_cyc = pc; mack_v = mack; mack_rd = mrdata; mack_er = merr;
            $display("cyc=%0d mack=%b rdata=%o err=%0d", pc, mack, mrdata, merr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [N-1:0] m);
        mreq = m;
        pulse_cyc = pc;
        tick();
        mreq = '0;
    endtask

    task automatic wait_req();
        int w = 0;
        while (dmareq !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        if (dmareq !== 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_dmareq cyc=%0d got=0 exp=1", pc);
        end
    endtask

    // Acknowledge the next dmareq 'delay' cycles later; 'mid' is pulsed on mreq one cycle after dmareq.
    task automatic serve(input int delay, input logic [15:0] rd, input logic er, input logic [N-1:0] mid);
        wait_req();
        if (dmareq !== 1'b1) return;
        for (int i = 1; i <= delay; i++) begin
            tick();
            mreq = (i == 1) ? mid : '0;
        end
        dmaack = 1'b1; dmardata = rd; dmaerr = er;
        tick();
        dmaack = 1'b0; dmardata = '0; dmaerr = 1'b0; mreq = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", pc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int mc, sm, rc;
        maddr[18*0 +: 18] = 18'o010000;
        maddr[18*1 +: 18] = 18'o017000;
        maddr[18*2 +: 18] = 18'o020000;
        maddr[18*3 +: 18] = 18'o030000;
        for (int i = 0; i < N; i++) mwdata[16*i +: 16] = 16'(16'o001000 + i);

        // Reset state
        tick(); tick();
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_mack",   32'(mack),   32'd0);
        check("rst_dmareq", 32'(dmareq), 32'd0);
        rstn = 1'b1;
        tick();

        // Single read from master 1
        pulse(4'b0010);
        serve(3, 16'o123456, 1'b0, '0);
        tick();
        check("rd_lat_req", req_cyc - pulse_cyc, 1);
        check("rd_addr",    32'(req_addr), 32'(18'o017000));
        check("rd_wr",      32'(req_wr),   32'd0);
        check("rd_lat_ack", mack_cyc - req_cyc, 4);
        check("rd_mack",    32'(mack_v),   32'b0010);
        check("rd_data",    32'(mack_rd),  32'(16'o123456));
        check("rd_err",     32'(mack_er),  32'd0);

        // Round-robin ordering after reset
        rstn = 1'b0; tick(); tick(); rstn = 1'b1; tick();
        order.delete();
        pulse(4'b1101);
        serve(2, 16'h0a00, 1'b0, '0);
        serve(2, 16'h0a02, 1'b0, '0);
        serve(3, 16'h0a03, 1'b0, 4'b1001);
        serve(2, 16'h0b00, 1'b0, '0);
        serve(2, 16'h0b03, 1'b0, '0);
        repeat (5) tick();
        check("rr_len", order.size(), 5);
        for (int i = 0; i < 5 && i < order.size(); i++)
            check($sformatf("rr_order%0d", i), order[i], exp_rr[i]);

        // Write with bus error from master 3
        maddr[18*3 +: 18]  = 18'o000100;
        mwdata[16*3 +: 16] = 16'o177777;
        mwr = 4'b1000;
        pulse(4'b1000);
        serve(2, 16'o000055, 1'b1, '0);
        tick();
        check("wr_wr",    32'(req_wr),  32'd1);
        check("wr_addr",  32'(req_addr), 32'(18'o000100));
        check("wr_wdata", 32'(req_wd),  32'(16'o177777));
        check("wr_mack",  32'(mack_v),  32'b1000);
        check("wr_err",   32'(mack_er), 32'd1);
        check("wr_rdata", 32'(mack_rd), 32'(16'o000055));
        mwr = '0;

        // Timeout: no ack from the mux, then a stray ack while idle
        mc = mack_cnt;
        pulse(4'b0100);
        for (int w = 0; w < 30 && mack_cnt == mc; w++) tick();
        check("to_seen",  mack_cnt, mc + 1);
        check("to_lat",   mack_cyc - req_cyc, TO);
        check("to_mack",  32'(mack_v),  32'b0100);
        check("to_err",   32'(mack_er), 32'd1);
        check("to_rdata", 32'(mack_rd), 32'd0);
        tick(); tick();
        dmaack = 1'b1; dmardata = 16'hbeef;
        tick();
        dmaack = 1'b0; dmardata = '0;
        repeat (4) tick();
        check("to_stray_ack", mack_cnt, mc + 1);
        check("to_hold_rd",   32'(mrdata), 32'd0);

        // New request from master 2 in the same cycle as its mack
        rc = req_cnt;
        pulse(4'b0100);
        serve(2, 16'h1234, 1'b0, '0);
        check("sim_mack", 32'(mack), 32'b0100);
        sm = pc;
        pulse(4'b0100);
        serve(2, 16'h4321, 1'b0, '0);
        check("sim_gap",    req_cyc - sm, 1);
        check("sim_master", master_of(req_addr), 2);
        repeat (5) tick();
        check("sim_reqs", req_cnt - rc, 2);

        // Reset while waiting for the mux
        pulse(4'b0010);
        wait_req();
        tick(); tick();
        rstn = 1'b0;
        #1;
        check("mrst_busy",   32'(busy),    32'd0);
        check("mrst_dmareq", 32'(dmareq),  32'd0);
        check("mrst_addr",   32'(dmaaddr), 32'd0);
        check("mrst_rdata",  32'(mrdata),  32'd0);
        check("mrst_mack",   32'(mack),    32'd0);
        tick();
        rstn = 1'b1;
        mc = mack_cnt;
        repeat (6) tick();
        check("mrst_no_mack", mack_cnt, mc);
        order.delete();
        pulse(4'b1111);
        for (int i = 0; i < N; i++) serve(1, 16'(16'h0c00 + i), 1'b0, '0);
        repeat (3) tick();
        check("mrst_len", order.size(), N);
        for (int i = 0; i < N && i < order.size(); i++)
            check($sformatf("mrst_order%0d", i), order[i], i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
